// File: rtl/multicycle_control.sv
// Multicycle datapath controller: Moore FSM that sequences fetch, decode
// and per-instruction execute/writeback for lw, sw, R-type, beq, addi and j.
//
// state  | meaning
// -------+--------------------------------------------------------------
// START  | post-reset idle, all strobes low
// FETCH  | load IR from memory[PC], PC <= PC + 4
// DECODE | compute branch target into ALUOut, dispatch on opcode
// MEMADR | effective address = A + sign-extended immediate
// MEMRD  | read memory at ALUOut into MDR
// MEMWB  | write MDR to register rt
// MEMWR  | write B to memory at ALUOut
// EXEC   | R-type ALU operation on A and B
// ALUWB  | write ALUOut to register rd
// BRANCH | compare A and B, conditional PC load from ALUOut
// ADDIEX | A + sign-extended immediate
// ADDIWB | write ALUOut to register rt
// JUMP   | PC <= jump target
module multicycle_control #(
  parameter int OP_WIDTH    = 6,
  parameter int STATE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OP_WIDTH-1:0]    opcode_i,
  output logic                   ir_write_o,
  output logic                   pc_write_o,
  output logic                   branch_o,
  output logic                   iord_o,
  output logic                   mem_write_o,
  output logic                   mem_to_reg_o,
  output logic                   reg_dst_o,
  output logic                   reg_write_o,
  output logic                   alu_src_a_o,
  output logic [1:0]             alu_src_b_o,
  output logic [1:0]             alu_op_o,
  output logic [1:0]             pc_src_o,
  output logic                   illegal_o,
  output logic [STATE_WIDTH-1:0] state_o
);

  typedef enum logic [3:0] {
    START  = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    JUMP   = 4'd12
  } state_t;

  localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(6'b100011);
  localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(6'b101011);
  localparam logic [OP_WIDTH-1:0] OP_RTYP = OP_WIDTH'(6'b000000);
  localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(6'b000100);
  localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(6'b001000);
  localparam logic [OP_WIDTH-1:0] OP_J    = OP_WIDTH'(6'b000010);

  state_t state_q, state_d;

  // State register; reset forces START immediately, even mid-instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= START;
    else       state_q <= state_d;
  end

  // Next-state and Moore output decode; only illegal_o also looks at the opcode.
  always_comb begin
    state_d      = state_q;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    branch_o     = 1'b0;
    iord_o       = 1'b0;
    mem_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_dst_o    = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 2'b00;
    pc_src_o     = 2'b00;
    illegal_o    = 1'b0;
    case (state_q)
      START: state_d = FETCH;
      FETCH: begin
        ir_write_o  = 1'b1;
        pc_write_o  = 1'b1;
        alu_src_b_o = 2'b01;
        state_d     = DECODE;
      end
      DECODE: begin
        alu_src_b_o = 2'b11;
        if (opcode_i == OP_LW || opcode_i == OP_SW) state_d = MEMADR;
        else if (opcode_i == OP_RTYP)                state_d = EXEC;
        else if (opcode_i == OP_BEQ)                 state_d = BRANCH;
        else if (opcode_i == OP_ADDI)                state_d = ADDIEX;
        else if (opcode_i == OP_J)                   state_d = JUMP;
        else begin
          illegal_o = 1'b1;
          state_d   = FETCH;
        end
      end
      MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        // Opcode is looked at again here rather than remembered from DECODE.
        state_d     = (opcode_i == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord_o  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        state_d      = FETCH;
      end
      MEMWR: begin
        iord_o      = 1'b1;
        mem_write_o = 1'b1;
        state_d     = FETCH;
      end
      EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b10;
        state_d     = ALUWB;
      end
      ALUWB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        state_d     = FETCH;
      end
      BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b01;
        branch_o    = 1'b1;
        pc_src_o    = 2'b01;
        state_d     = FETCH;
      end
      ADDIEX: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_d     = ADDIWB;
      end
      ADDIWB: begin
        reg_write_o = 1'b1;
        state_d     = FETCH;
      end
      JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = 2'b10;
        state_d    = FETCH;
      end
      // Unused encodings recover to FETCH with every output low.
      default: state_d = FETCH;
    endcase
  end

  assign state_o = STATE_WIDTH'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each instruction pushes its
// expected per-cycle state/output records, and every falling edge pops one
// and compares it against the DUT.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode_i = 6'b000000;
  logic       ir_write_o, pc_write_o, branch_o, iord_o, mem_write_o;
  logic       mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, illegal_o;
  logic [1:0] alu_src_b_o, alu_op_o, pc_src_o;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;

  logic [19:0] sb_q[$];

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  multicycle_control #(.OP_WIDTH(6), .STATE_WIDTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode_i     (opcode_i),
    .ir_write_o   (ir_write_o),
    .pc_write_o   (pc_write_o),
    .branch_o     (branch_o),
    .iord_o       (iord_o),
    .mem_write_o  (mem_write_o),
    .mem_to_reg_o (mem_to_reg_o),
    .reg_dst_o    (reg_dst_o),
    .reg_write_o  (reg_write_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .pc_src_o     (pc_src_o),
    .illegal_o    (illegal_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  wire [15:0] outs = {ir_write_o, pc_write_o, branch_o, iord_o, mem_write_o,
                      mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o,
                      alu_src_b_o, alu_op_o, pc_src_o, illegal_o};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected outputs per state, written straight from the state descriptions.
  function automatic logic [15:0] exp_out(input logic [3:0] st, input logic ill);
    logic ir, pcw, br, io, mw, m2r, rd, rw, sa, il;
    logic [1:0] sb, op, ps;
    {ir, pcw, br, io, mw, m2r, rd, rw, sa, il} = '0;
    sb = 2'b00; op = 2'b00; ps = 2'b00;
    case (st)
      4'd1:  begin ir = 1; pcw = 1; sb = 2'b01; end
      4'd2:  begin sb = 2'b11; il = ill; end
      4'd3:  begin sa = 1; sb = 2'b10; end
      4'd4:  io = 1;
      4'd5:  begin rw = 1; m2r = 1; end
      4'd6:  begin io = 1; mw = 1; end
      4'd7:  begin sa = 1; op = 2'b10; end
      4'd8:  begin rw = 1; rd = 1; end
      4'd9:  begin sa = 1; op = 2'b01; br = 1; ps = 2'b01; end
      4'd10: begin sa = 1; sb = 2'b10; end
      4'd11: rw = 1;
      4'd12: begin pcw = 1; ps = 2'b10; end
      default: ;
    endcase
    return {ir, pcw, br, io, mw, m2r, rd, rw, sa, sb, op, ps, il};
  endfunction

  task automatic push(input logic [3:0] st, input logic ill);
    sb_q.push_back({st, exp_out(st, ill)});
  endtask

  task automatic compare_next(input string name);
    logic [19:0] e;
    if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    chk($sformatf("%s_state", name), 32'(state_o), 32'(e[19:16]));
    chk($sformatf("%s_outs_st%0d", name, e[19:16]), 32'(outs), 32'(e[15:0]));
    chk($sformatf("%s_wr_excl", name),
        32'(int'(ir_write_o) + int'(mem_write_o) + int'(reg_write_o) <= 1), 32'd1);
  endtask

  // Starting from a sampled FETCH: op is seen in DECODE, op2 from MEMADR on.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] op2);
    int cyc;
    opcode_i = op;
    case (op)
      LW, SW: begin
        push(4'd2, 0); push(4'd3, 0);
        if (op2 == SW) push(4'd6, 0);
        else begin push(4'd4, 0); push(4'd5, 0); end
      end
      RT:      begin push(4'd2, 0); push(4'd7, 0); push(4'd8, 0); end
      BEQ:     begin push(4'd2, 0); push(4'd9, 0); end
      ADDI:    begin push(4'd2, 0); push(4'd10, 0); push(4'd11, 0); end
      JMP:     begin push(4'd2, 0); push(4'd12, 0); end
      default: push(4'd2, 1);
    endcase
    push(4'd1, 0);
    cyc = 0;
    while (sb_q.size() > 0 && cyc < 20) begin
      @(negedge clk);
      compare_next(name);
      opcode_i = op2;
      cyc++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_outs", 32'(outs), 32'd0);
    @(negedge clk);
    chk("rst_state2", 32'(state_o), 32'd0);
    chk("rst_outs2", 32'(outs), 32'd0);
    reset = 1'b0;
    opcode_i = LW;
    push(4'd0, 0);
    compare_next("start");
    push(4'd1, 0);
    @(negedge clk);
    compare_next("first_fetch");

    run_instr("lw", LW, LW);
    run_instr("rtype", RT, RT);
    run_instr("sw", SW, SW);
    run_instr("beq", BEQ, BEQ);
    run_instr("j", JMP, JMP);
    run_instr("addi", ADDI, ADDI);
    run_instr("ill_3f", 6'b111111, 6'b111111);
    run_instr("ill_01", 6'b000001, 6'b000001);
    run_instr("lw_then_sw", LW, SW);
    run_instr("sw_then_lw", SW, LW);
    run_instr("rtype2", RT, RT);

    // Reset asserted in the middle of MEMRD must take effect before the next edge.
    opcode_i = LW;
    push(4'd2, 0); push(4'd3, 0); push(4'd4, 0);
    repeat (3) begin
      @(negedge clk);
      compare_next("lw_pre_rst");
    end
    #2 reset = 1'b1;
    #1;
    chk("async_rst_state", 32'(state_o), 32'd0);
    chk("async_rst_outs", 32'(outs), 32'd0);
    @(negedge clk);
    chk("held_rst_state", 32'(state_o), 32'd0);
    chk("held_rst_outs", 32'(outs), 32'd0);
    reset = 1'b0;
    push(4'd0, 0);
    compare_next("post_rst_start");
    push(4'd1, 0);
    @(negedge clk);
    compare_next("post_rst_fetch");
    run_instr("beq2", BEQ, BEQ);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
